imem_loader: RTL and testbench
==============================

# imem_loader

Byte-serial instruction-memory loader for the single-cycle MIPS core. It accepts a framed byte stream over a valid/ready handshake and packs it into big-endian 32-bit words. It writes those words into instruction memory at consecutive word addresses, and holds the fetch stage's PC reset asserted until the program image is complete. It is the write side of the instruction memory that the fetch stage reads.

## Interface
- ADDR_W, 8, word-address width of instruction memory (capacity 2^ADDR_W words)
- BASE_ADDR, 0, first word address written
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_valid  input  1  source has a byte on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  word address for the write
- mem_wdata  output  32  instruction word
- cpu_hold  output  1  drives the fetch stage's reset; 1 = PC held in reset
- busy  output  1  load in progress
- done  output  1  image loaded, level until next start or reset
- error  output  1  load aborted, level until next start or reset

## Operation
- Frame format: COUNT_HI, COUNT_LO, then 4*N data bytes with the first byte as bits 31:24. N is a 16-bit word count.
- FSM states: IDLE, CNT_HI, CNT_LO, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start → CNT_HI. Addr counter := BASE_ADDR, byte index := 0, done/error cleared.
- CNT_HI → CNT_LO on accepted byte.
- CNT_LO, on accepted byte:
  - N == 0 → CHECK.
  - BASE_ADDR + N > 2^ADDR_W → ERROR. The test is done on a 17-bit sum; no wrap-around is permitted.
  - Otherwise → DATA.
- DATA accepts bytes; on the 4th byte of a word → WRITE.
- WRITE asserts mem_we for exactly one cycle and in_ready = 0. The address then increments.
  - If words remain → DATA.
  - If this was the last word → CHECK.
- CHECK: with CHECKSUM_EN, waits for one checksum byte (see Configuration). Without it, passes through to DONE in one cycle with in_ready = 0.
- DONE: cpu_hold = 0, done = 1.
- ERROR: cpu_hold = 1, error = 1, in_ready = 0.
- start while busy is ignored.
- Bytes offered in IDLE/DONE/ERROR are not accepted (in_ready = 0).
- Reset mid-load returns to IDLE with cpu_hold = 1. Partially written memory contents are left as-is.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_hold 1, busy 0, done 0, error 0.
- in_ready is registered: 1 in CNT_HI, CNT_LO, DATA and CHECK (checksum build only), 0 elsewhere.
- mem_we rises the cycle after the 4th byte of a word is accepted. mem_addr/mem_wdata are stable during that cycle.
- Throughput: 5 cycles per word with in_valid held high.
- busy is 1 from the cycle after start until the cycle DONE or ERROR is entered.
- cpu_hold falls in the same cycle done rises.
- A start in DONE re-asserts cpu_hold on the next cycle.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The frame carries one trailing byte after the data: the XOR of all preceding frame bytes, count bytes included.
  - CHECK accepts that byte. Match → DONE; mismatch → ERROR.
- Undefined: no checksum byte is expected. CHECK → DONE directly, and the XOR accumulator is absent.

## Structure
- Package imem_loader_pkg holds:
  - the state enum
  - BYTES_PER_WORD = 4
  - COUNT_W = 16
- Sub-module imem_byte_packer holds:
  - the 4-byte big-endian shift register
  - the 2-bit byte index
  - a word_full flag
- The FSM, address/word counters and optional checksum stay in imem_loader.

## Test plan
- Reset low then high, no start → cpu_hold 1, in_ready 0, mem_we never asserted.
- start; stream 00 02 20 08 00 05 20 09 00 07 → writes 0x20080005 @0 and 0x20090007 @1, one mem_we each; then done 1, cpu_hold 0.
- start; count 00 00 → no writes, done 1 (with checksum build: checksum byte 00 required first).
- ADDR_W = 4, BASE_ADDR = 0, count 00 11 (17 > 16) → error 1, cpu_hold 1, no mem_we.
- Reset pulled low after 2 of 4 words written, then start a fresh 1-word load → state returns to IDLE, cpu_hold 1; the new word is written @0 and done asserts.
- With IMEM_LOADER_CHECKSUM_EN: frame 00 01 12 34 56 78 + checksum 09 → done. With checksum 08 → error, cpu_hold stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared types and constants for the instruction-memory loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_byte_packer.sv
// ============================================================================
// Module : imem_byte_packer
// Brief  : Packs a byte stream into big-endian 32-bit words (first byte MSB).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;

    // Combinational so the FSM can leave DATA on the same edge the 4th byte lands
    assign word_full = shift_en && (r_byte_idx == 2'(BYTES_PER_WORD - 1));
    assign word      = r_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word     <= 32'd0;
            r_byte_idx <= 2'd0;
        end else if (clear) begin
            r_byte_idx <= 2'd0;
        end else if (shift_en) begin
            r_word     <= {r_word[23:0], byte_in};
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Framed byte-stream loader for instruction memory; holds the CPU
//          in reset until the image is in. IMEM_LOADER_CHECKSUM_EN adds a
//          trailing XOR checksum byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] c_capacity = 17'(1) << ADDR_W;
    localparam logic [16:0] c_base     = 17'(BASE_ADDR);

    state_t              r_state;
    state_t              w_next;
    logic                w_start;
    logic                w_accept;
    logic                w_word_full;
    logic [COUNT_W-1:0]  w_count;
    logic [16:0]         w_sum;
    logic [7:0]          r_count_hi;
    logic [COUNT_W-1:0]  r_words_left;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_in_ready;
    logic                r_mem_we;
    logic                r_cpu_hold;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    assign w_accept = in_valid && r_in_ready;
    assign w_count  = {r_count_hi, in_data};
    assign w_sum    = c_base + {1'b0, w_count};

    imem_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_start),
        .shift_en  (w_accept && (r_state == S_DATA)),
        .byte_in   (in_data),
        .word      (mem_wdata),
        .word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_next  = S_CNT_HI;
                    w_start = 1'b1;
                end
            end
            S_CNT_HI: if (w_accept) w_next = S_CNT_LO;
            S_CNT_LO: begin
                if (w_accept) begin
                    if (w_count == '0)            w_next = S_CHECK;
                    else if (w_sum > c_capacity) w_next = S_ERROR;
                    else                         w_next = S_DATA;
                end
            end
            S_DATA:  if (w_word_full) w_next = S_WRITE;
            S_WRITE: w_next = (r_words_left == COUNT_W'(1)) ? S_CHECK : S_DATA;
            S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_accept) w_next = (in_data == r_csum) ? S_DONE : S_ERROR;
`else
                w_next = S_DONE;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered off the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_in_ready <= (w_next == S_CNT_HI) || (w_next == S_CNT_LO) ||
                          (w_next == S_DATA)   || (w_next == S_CHECK);
`else
            r_in_ready <= (w_next == S_CNT_HI) || (w_next == S_CNT_LO) ||
                          (w_next == S_DATA);
`endif
            r_mem_we   <= (w_next == S_WRITE);
            r_cpu_hold <= (w_next != S_DONE);
            r_busy     <= (w_next != S_IDLE) && (w_next != S_DONE) && (w_next != S_ERROR);
            r_done     <= (w_next == S_DONE);
            r_error    <= (w_next == S_ERROR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= ADDR_W'(BASE_ADDR);
            r_count_hi   <= 8'd0;
            r_words_left <= '0;
        end else if (w_start) begin
            r_addr       <= ADDR_W'(BASE_ADDR);
            r_words_left <= '0;
        end else begin
            if (r_state == S_CNT_HI && w_accept) r_count_hi   <= in_data;
            if (r_state == S_CNT_LO && w_accept) r_words_left <= w_count;
            if (r_state == S_WRITE) begin
                r_addr       <= r_addr + ADDR_W'(1);
                r_words_left <= r_words_left - COUNT_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over count and data bytes; the trailing byte must match it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= 8'd0;
        end else if (w_start) begin
            r_csum <= 8'd0;
        end else if (w_accept && (r_state == S_CNT_HI || r_state == S_CNT_LO ||
                                  r_state == S_DATA)) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    assign in_ready = r_in_ready;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_addr;
    assign cpu_hold = r_cpu_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Directed table-driven bench for imem_loader (ADDR_W=8 and ADDR_W=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        hold;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_start, a_valid;
    logic [7:0]  a_data;
    logic        a_rdy, a_we, a_hold, a_busy, a_done, a_err;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;

    logic        b_reset, b_start, b_valid;
    logic [7:0]  b_data;
    logic        b_rdy, b_we, b_hold, b_busy, b_done, b_err;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;

    int n_vec = 0;
    int n_bad = 0;
    int b_we_cnt = 0;
    int a_we_idle = 0;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .in_valid(a_valid),
        .in_data(a_data), .in_ready(a_rdy), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .cpu_hold(a_hold), .busy(a_busy), .done(a_done),
        .error(a_err)
    );

    imem_loader #(.ADDR_W(4), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .in_valid(b_valid),
        .in_data(b_data), .in_ready(b_rdy), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .cpu_hold(b_hold), .busy(b_busy), .done(b_done),
        .error(b_err)
    );

    always @(posedge clk) if (b_we === 1'b1) b_we_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input vec_t v);
        chk({tag, ".in_ready"}, 32'(a_rdy),  32'(v.rdy));
        chk({tag, ".mem_we"},   32'(a_we),   32'(v.we));
        chk({tag, ".mem_addr"}, 32'(a_addr), 32'(v.addr));
        if (v.we) chk({tag, ".mem_wdata"}, a_wdata, v.wdata);
        chk({tag, ".cpu_hold"}, 32'(a_hold), 32'(v.hold));
        chk({tag, ".busy"},     32'(a_busy), 32'(v.busy));
        chk({tag, ".done"},     32'(a_done), 32'(v.done));
        chk({tag, ".error"},    32'(a_err),  32'(v.err));
    endtask

    function automatic vec_t mk(bit s, bit v, logic [7:0] d, bit rdy, bit we,
                                logic [7:0] a, logic [31:0] w, bit h, bit b,
                                bit dn, bit e);
        vec_t r;
        r.start = s; r.valid = v; r.data = d; r.rdy = rdy; r.we = we;
        r.addr = a; r.wdata = w; r.hold = h; r.busy = b; r.done = dn; r.err = e;
        return r;
    endfunction

    task automatic step_a(input bit s, input bit v, input logic [7:0] d);
        @(negedge clk);
        a_start = s; a_valid = v; a_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input bit s, input bit v, input logic [7:0] d);
        @(negedge clk);
        b_start = s; b_valid = v; b_data = d;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t e;

    initial begin
        a_reset = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_data = 8'h00;
        b_reset = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;

        //        s  v  data   rdy we addr wdata         hold busy done err
        tbl.push_back(mk(1, 0, 8'h00, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h00, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h02, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(1, 1, 8'h20, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h08, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h00, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h05, 0,  1,  0, 32'h20080005, 1,  1,  0,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1,  0,  1, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h20, 1,  0,  1, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h09, 1,  0,  1, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h00, 1,  0,  1, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h07, 0,  1,  1, 32'h20090007, 1,  1,  0,  0));
        tbl.push_back(mk(0, 0, 8'h00, CS, 0,  2, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h01, 0,  0,  2, 32'h0,        0,  0,  1,  0));
        tbl.push_back(mk(1, 0, 8'h00, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h00, 1,  0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h00, CS, 0,  0, 32'h0,        1,  1,  0,  0));
        tbl.push_back(mk(0, 1, 8'h00, 0,  0,  0, 32'h0,        0,  0,  1,  0));
        tbl.push_back(mk(0, 1, 8'hFF, 0,  0,  0, 32'h0,        0,  0,  1,  0));

        // Held in reset, then idle with no start
        repeat (3) @(posedge clk);
        #1;
        e = mk(0, 0, 8'h00, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        chk_a("rst_low", e);
        chk("rst_low.mem_wdata", a_wdata, 32'h0);
        @(negedge clk);
        a_reset = 1'b1; b_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (a_we !== 1'b0) a_we_idle++;
        end
        chk_a("idle", e);
        chk("idle.no_we", 32'(a_we_idle), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step_a(tbl[i].start, tbl[i].valid, tbl[i].data);
            chk_a($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset after two of four words, then a fresh one-word load
        step_a(1, 0, 8'h00);
        step_a(0, 1, 8'h00);
        step_a(0, 1, 8'h04);
        step_a(0, 1, 8'h11); step_a(0, 1, 8'h22); step_a(0, 1, 8'h33); step_a(0, 1, 8'h44);
        chk_a("abort.w0", mk(0, 0, 0, 0, 1, 0, 32'h11223344, 1, 1, 0, 0));
        step_a(0, 0, 8'h00);
        step_a(0, 1, 8'h55); step_a(0, 1, 8'h66); step_a(0, 1, 8'h77); step_a(0, 1, 8'h88);
        chk_a("abort.w1", mk(0, 0, 0, 0, 1, 1, 32'h55667788, 1, 1, 0, 0));
        step_a(0, 0, 8'h00);
        step_a(0, 1, 8'h99);
        @(negedge clk);
        a_valid = 1'b0;
        a_reset = 1'b0;
        #1;
        chk_a("abort.rst", mk(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
        @(negedge clk);
        a_reset = 1'b1;
        step_a(1, 0, 8'h00);
        step_a(0, 1, 8'h00);
        step_a(0, 1, 8'h01);
        step_a(0, 1, 8'hAB); step_a(0, 1, 8'hCD); step_a(0, 1, 8'hEF); step_a(0, 1, 8'h01);
        chk_a("reload.w", mk(0, 0, 0, 0, 1, 0, 32'hABCDEF01, 1, 1, 0, 0));
        step_a(0, 0, 8'h00);
        step_a(0, 1, 8'h89);
        chk_a("reload.done", mk(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 1, 0));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 00^01^12^34^56^78 = 09
        step_a(1, 0, 8'h00);
        step_a(0, 1, 8'h00); step_a(0, 1, 8'h01);
        step_a(0, 1, 8'h12); step_a(0, 1, 8'h34); step_a(0, 1, 8'h56); step_a(0, 1, 8'h78);
        step_a(0, 0, 8'h00);
        chk("cs_ok.ready_in_check", 32'(a_rdy), 32'd1);
        step_a(0, 1, 8'h09);
        chk_a("cs_ok", mk(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 1, 0));
        step_a(1, 0, 8'h00);
        step_a(0, 1, 8'h00); step_a(0, 1, 8'h01);
        step_a(0, 1, 8'h12); step_a(0, 1, 8'h34); step_a(0, 1, 8'h56); step_a(0, 1, 8'h78);
        step_a(0, 0, 8'h00);
        step_a(0, 1, 8'h08);
        chk_a("cs_bad", mk(0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 1));
        step_a(0, 0, 8'h00);
`endif

        // 16-word memory: 17 words overflows, 16 words exactly fits
        step_b(1, 0, 8'h00);
        step_b(0, 1, 8'h00);
        step_b(0, 1, 8'h11);
        chk("ovf.error",    32'(b_err),  32'd1);
        chk("ovf.cpu_hold", 32'(b_hold), 32'd1);
        chk("ovf.in_ready", 32'(b_rdy),  32'd0);
        chk("ovf.busy",     32'(b_busy), 32'd0);
        chk("ovf.done",     32'(b_done), 32'd0);
        step_b(0, 1, 8'h55);
        chk("ovf.stays",    32'(b_err),  32'd1);
        step_b(1, 0, 8'h00);
        chk("ovf.restart_clr", 32'(b_err), 32'd0);
        step_b(0, 1, 8'h00);
        step_b(0, 1, 8'h10);
        chk("fit.error",    32'(b_err),  32'd0);
        chk("fit.busy",     32'(b_busy), 32'd1);
        chk("fit.in_ready", 32'(b_rdy),  32'd1);
        step_b(0, 0, 8'h00);
        chk("b.no_we", 32'(b_we_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
